monitor_jogada: RTL and testbench
=================================

MONITOR_JOGADA -- requirements
Module: monitor_jogada

Interface
REQ-001 Parameter DEB_CICLOS, default 4: consecutive stable cycles required to accept a press or a release (≥2).
REQ-002 Parameter TIMEOUT_CICLOS, default 5000: cycles of estado_espera=1 without a play before timeout (≥2).
REQ-003 clock  in  1  single system clock, all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-005 botoes  in  4  raw, asynchronous button levels, 1 = pressed.
REQ-006 estado_espera  in  1  from the control unit; 1 = waiting for a play, enables the timeout count.
REQ-007 limpa  in  1  synchronous clear of jogada and the timeout counter (driven with zeraR).
REQ-008 tem_jogada  out  1  one-cycle pulse per accepted press.
REQ-009 jogada  out  4  one-hot code of the last accepted press, held.
REQ-010 timeout  out  1  no play within TIMEOUT_CICLOS cycles of waiting.
REQ-011 db_estado  out  3  debug FSM state code.

Function
REQ-012 botoes SHALL pass through a 2-flop synchronizer; FSM and counters see only the synchronized value b_s.
REQ-013 FSM states and db_estado codes: OCIOSO=0, FILTRA=1, ACEITA=2, SEGURA=3, LIBERA=4; unused codes → OCIOSO.
REQ-014 OCIOSO: b_s one-hot → FILTRA, load candidate=b_s, cnt=0; b_s zero or multi-hot → stay.
REQ-015 FILTRA: b_s≠candidate → OCIOSO; b_s=candidate and cnt=DEB_CICLOS-1 → ACEITA; else cnt+1.
REQ-016 ACEITA lasts exactly one cycle: tem_jogada=1, jogada loaded with candidate on the entry edge; next state SEGURA.
REQ-017 SEGURA: stays while b_s≠0, ignoring any other button changes; b_s=0 → LIBERA, cnt=0.
REQ-018 LIBERA: b_s≠0 → SEGURA; b_s=0 and cnt=DEB_CICLOS-1 → OCIOSO; else cnt+1.
REQ-019 Latency: a clean press stable from before edge k SHALL give tem_jogada=1 in the cycle after edge k+DEB_CICLOS+2; held press gives exactly one pulse.
REQ-020 Multi-button press SHALL never produce tem_jogada; pressing a second button during FILTRA aborts the candidate.
REQ-021 Timeout counter (width ceil(log2(TIMEOUT_CICLOS))) SHALL increment each cycle estado_espera=1, saturate at TIMEOUT_CICLOS-1, and clear when estado_espera=0, tem_jogada=1 or limpa=1.
REQ-022 timeout = estado_espera AND cnt_to=TIMEOUT_CICLOS-1 AND NOT tem_jogada; first high in the TIMEOUT_CICLOS-th consecutive waiting cycle, held while estado_espera stays 1.
REQ-023 tem_jogada and timeout SHALL never be 1 in the same cycle; press wins on coincidence.
REQ-024 limpa SHALL clear jogada to 0 and the timeout counter; it SHALL NOT affect FSM state or a tem_jogada pulse in the same cycle (jogada load wins over limpa).

Reset
REQ-025 reset=0 SHALL asynchronously set: synchronizer flops 0, FSM OCIOSO, all counters 0, candidate 0, jogada 0, tem_jogada 0, timeout 0, db_estado 0.
REQ-026 Reset mid-press SHALL discard the press; after release of reset a still-held button is re-filtered from OCIOSO (full latency of REQ-019).

Structure
REQ-027 State encodings and default DEB_CICLOS/TIMEOUT_CICLOS SHALL live in the shared jogo_pkg constants file, reused by the control unit.
REQ-028 One sub-module SHALL be instantiated: sincronizador_2ff (4-bit, same clock/reset); everything else in monitor_jogada.

Verification
REQ-029 Reset, botoes=0010 stable → tem_jogada=1 exactly one cycle after edge 7 (DEB=4), jogada=0010 held; no second pulse while held 50 cycles.
REQ-030 botoes=0001 for 3 cycles then 0 (bounce) → no tem_jogada, db_estado returns to 0.
REQ-031 botoes=0101 for 20 cycles → no tem_jogada, db_estado stays 0.
REQ-032 TIMEOUT_CICLOS=10, estado_espera=1 constant, no press → timeout=1 from 10th cycle; estado_espera=0 → timeout=0 next cycle and counter cleared.
REQ-033 Press accepted on the cycle timeout would rise → tem_jogada=1, timeout=0; counter restarts from 0.
REQ-034 reset=0 asserted during FILTRA and during ACEITA → outputs 0 immediately; limpa=1 with jogada=1000 → jogada=0000 next cycle.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared game constants: FSM state encodings for the play monitor and default timing.
// Also used by the control unit, so the encodings here are the debug codes seen on db_estado.
package jogo_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    FILTRA = 3'd1,
    ACEITA = 3'd2,
    SEGURA = 3'd3,
    LIBERA = 3'd4
  } estado_t;

  localparam int DEB_CICLOS_PADRAO     = 4;
  localparam int TIMEOUT_CICLOS_PADRAO = 5000;

  function automatic logic eh_um_quente(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/monitor_jogada_if.sv
// Play-monitor signal bundle: raw buttons and control in, accepted play / timeout / debug out.
// master = control-unit side, slave = monitor side.
interface monitor_jogada_if;
  logic [3:0] botoes;
  logic       estado_espera;
  logic       limpa;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic       timeout;
  logic [2:0] db_estado;

  modport master (
    output botoes, estado_espera, limpa,
    input  tem_jogada, jogada, timeout, db_estado
  );

  modport slave (
    input  botoes, estado_espera, limpa,
    output tem_jogada, jogada, timeout, db_estado
  );
endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency, no backpressure.
module sincronizador_2ff #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/monitor_jogada.sv
// Button debouncer/play detector with waiting timeout: one tem_jogada pulse per accepted one-hot press,
// DEB_CICLOS+2 cycles after the press reaches the synchronizer; no backpressure (pulse-only output).
module monitor_jogada
  import jogo_pkg::*;
#(
  parameter int DEB_CICLOS     = DEB_CICLOS_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input logic             clock,
  input logic             reset,
  monitor_jogada_if.slave bus
);

  localparam int DW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CICLOS - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CICLOS - 1);

  logic [3:0]    b_s;
  estado_t       estado;
  logic [3:0]    candidato;
  logic [DW-1:0] cnt;
  logic          tem_jogada_q;
  logic [3:0]    jogada_q;
  logic [TW-1:0] cnt_to;

  sincronizador_2ff #(.LARGURA(4)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (bus.botoes),
    .q     (b_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      candidato    <= '0;
      cnt          <= '0;
      tem_jogada_q <= 1'b0;
      jogada_q     <= '0;
    end else begin
      tem_jogada_q <= 1'b0;
      // A load on entry to ACEITA below overrides this clear in the same cycle.
      if (bus.limpa)
        jogada_q <= '0;
      case (estado)
        OCIOSO: begin
          if (eh_um_quente(b_s)) begin
            estado    <= FILTRA;
            candidato <= b_s;
            cnt       <= '0;
          end
        end
        FILTRA: begin
          if (b_s != candidato) begin
            estado <= OCIOSO;
          end else if (cnt == DEB_MAX) begin
            estado       <= ACEITA;
            tem_jogada_q <= 1'b1;
            jogada_q     <= candidato;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACEITA: estado <= SEGURA;
        SEGURA: begin
          if (b_s == 4'd0) begin
            estado <= LIBERA;
            cnt    <= '0;
          end
        end
        LIBERA: begin
          if (b_s != 4'd0)
            estado <= SEGURA;
          else if (cnt == DEB_MAX)
            estado <= OCIOSO;
          else
            cnt <= cnt + 1'b1;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Saturating count of waiting cycles; an accepted press restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_to <= '0;
    else if (!bus.estado_espera || tem_jogada_q || bus.limpa)
      cnt_to <= '0;
    else if (cnt_to != TO_MAX)
      cnt_to <= cnt_to + 1'b1;
  end

  assign bus.tem_jogada = tem_jogada_q;
  assign bus.jogada     = jogada_q;
  assign bus.db_estado  = estado;
  assign bus.timeout    = bus.estado_espera && (cnt_to == TO_MAX) && !tem_jogada_q;

endmodule

// File: tb/tb_monitor_jogada.sv
// Directed self-checking bench for monitor_jogada (DEB_CICLOS=4, TIMEOUT_CICLOS=10).
module tb_monitor_jogada;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  monitor_jogada_if bus_if ();

  monitor_jogada #(
    .DEB_CICLOS     (4),
    .TIMEOUT_CICLOS (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    repeat (n) begin
      tick();
      if (bus_if.tem_jogada === 1'b1) p++;
    end
  endtask

  int p;
  int bad;

  initial begin
    bus_if.botoes        = 4'd0;
    bus_if.estado_espera = 1'b0;
    bus_if.limpa         = 1'b0;

    // Reset state
    #12;
    check("rst_tem",     32'(bus_if.tem_jogada), 0);
    check("rst_jogada",  32'(bus_if.jogada),     0);
    check("rst_timeout", 32'(bus_if.timeout),    0);
    check("rst_db",      32'(bus_if.db_estado),  0);

    // Clean press of 0010: pulse right after edge 7
    reset = 1'b1;
    bus_if.botoes = 4'b0010;
    tick(3);
    check("press_filtra_db", 32'(bus_if.db_estado), 1);
    tick(3);
    check("press_edge6_tem", 32'(bus_if.tem_jogada), 0);
    tick();
    check("press_edge7_tem", 32'(bus_if.tem_jogada), 1);
    check("press_jogada",    32'(bus_if.jogada),     4'b0010);
    check("press_aceita_db", 32'(bus_if.db_estado),  2);
    tick();
    check("press_edge8_tem", 32'(bus_if.tem_jogada), 0);
    check("press_segura_db", 32'(bus_if.db_estado),  3);
    count_pulses(50, p);
    check("held_pulses", p, 0);
    check("held_jogada", 32'(bus_if.jogada), 4'b0010);
    bus_if.botoes = 4'd0;
    tick(10);
    check("release_db",     32'(bus_if.db_estado), 0);
    check("release_jogada", 32'(bus_if.jogada),    4'b0010);

    // Bounce: 0001 for 3 cycles then released
    bus_if.botoes = 4'b0001;
    tick(3);
    check("bounce_filtra_db", 32'(bus_if.db_estado), 1);
    bus_if.botoes = 4'd0;
    count_pulses(10, p);
    check("bounce_pulses", p, 0);
    check("bounce_db",     32'(bus_if.db_estado), 0);

    // Multi-hot 0101 for 20 cycles
    bus_if.botoes = 4'b0101;
    p = 0;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus_if.tem_jogada === 1'b1) p++;
      if (bus_if.db_estado !== 3'd0) bad++;
    end
    check("multi_pulses",    p,   0);
    check("multi_db_nonzero", bad, 0);
    bus_if.botoes = 4'd0;
    tick(3);

    // Timeout: rises in the 10th waiting cycle, held, drops when waiting ends
    bus_if.estado_espera = 1'b1;
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      if (bus_if.timeout !== 1'b0) bad++;
      tick();
    end
    check("to_early",   bad, 0);
    check("to_rise",    32'(bus_if.timeout), 1);
    tick(3);
    check("to_held",    32'(bus_if.timeout), 1);
    bus_if.estado_espera = 1'b0;
    tick();
    check("to_drop",    32'(bus_if.timeout), 0);
    bus_if.estado_espera = 1'b1;
    tick(8);
    check("to_restart_c9",  32'(bus_if.timeout), 0);
    tick();
    check("to_restart_c10", 32'(bus_if.timeout), 1);
    bus_if.estado_espera = 1'b0;
    tick();

    // Press accepted in the cycle timeout would have risen
    bus_if.estado_espera = 1'b1;
    tick(2);
    bus_if.botoes = 4'b0100;
    tick(7);
    check("coinc_tem",     32'(bus_if.tem_jogada), 1);
    check("coinc_timeout", 32'(bus_if.timeout),    0);
    check("coinc_jogada",  32'(bus_if.jogada),     4'b0100);
    tick();
    check("coinc_after_timeout", 32'(bus_if.timeout), 0);
    tick(8);
    check("coinc_cnt_c9",  32'(bus_if.timeout), 0);
    tick();
    check("coinc_cnt_c10", 32'(bus_if.timeout), 1);
    bus_if.estado_espera = 1'b0;
    bus_if.botoes = 4'd0;
    tick(10);
    check("coinc_idle_db", 32'(bus_if.db_estado), 0);

    // Reset during FILTRA
    bus_if.botoes = 4'b1000;
    tick(3);
    check("rf_pre_db", 32'(bus_if.db_estado), 1);
    #2 reset = 1'b0;
    #1;
    check("rf_db",     32'(bus_if.db_estado),  0);
    check("rf_tem",    32'(bus_if.tem_jogada), 0);
    check("rf_jogada", 32'(bus_if.jogada),     0);
    #1 reset = 1'b1;
    tick(6);
    check("rf_refilter_e6", 32'(bus_if.tem_jogada), 0);
    tick();
    check("rf_refilter_e7", 32'(bus_if.tem_jogada), 1);
    check("rf_aceita_db",   32'(bus_if.db_estado),  2);

    // Reset during ACEITA
    #2 reset = 1'b0;
    #1;
    check("ra_tem",     32'(bus_if.tem_jogada), 0);
    check("ra_jogada",  32'(bus_if.jogada),     0);
    check("ra_db",      32'(bus_if.db_estado),  0);
    check("ra_timeout", 32'(bus_if.timeout),    0);
    #1 reset = 1'b1;
    tick(7);
    check("ra_repress_tem",    32'(bus_if.tem_jogada), 1);
    check("ra_repress_jogada", 32'(bus_if.jogada),     4'b1000);

    // limpa clears jogada without disturbing the FSM
    tick();
    bus_if.limpa = 1'b1;
    tick();
    bus_if.limpa = 1'b0;
    check("limpa_jogada", 32'(bus_if.jogada),    0);
    check("limpa_db",     32'(bus_if.db_estado), 3);
    bus_if.botoes = 4'd0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
